// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer: start handshake, SBOX latency wait, mux selects, key step and rcon.
// Optional abort input is enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int NR       = 10,
  parameter int SBOX_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic       abort,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       st_load,
  output logic [1:0] st_sel,
  output logic       key_load,
  output logic       key_step,
  output logic [7:0] rcon,
  output logic [3:0] round
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SUB,
    S_MIX,
    S_DONE
  } state_t;

  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [1:0] LAT_LAST = 2'(SBOX_LAT - 1);

  state_t     r_state;
  logic [3:0] r_round;
  logic [1:0] r_lat;
  logic [7:0] r_rc;
  logic       r_busy;
  logic       r_out_valid;
  logic       r_st_load;
  logic [1:0] r_st_sel;
  logic       r_key_load;
  logic       r_key_step;
  logic [7:0] r_rcon;

  logic       w_abort;
  logic       w_accept;
  logic       w_last_round;
  logic [7:0] w_xtime;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // In DONE the next block may be taken in the same cycle the result is consumed.
  assign in_ready     = ~r_busy | (r_out_valid & out_ready & ~w_abort);
  assign w_accept     = in_valid & in_ready;
  assign w_last_round = (r_round == NR_L);
  assign w_xtime      = {r_rc[6:0], 1'b0} ^ (r_rc[7] ? 8'h1B : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_round     <= 4'd0;
      r_lat       <= 2'd0;
      r_rc        <= 8'h01;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_st_load   <= 1'b0;
      r_st_sel    <= 2'd0;
      r_key_load  <= 1'b0;
      r_key_step  <= 1'b0;
      r_rcon      <= 8'h00;
    end else begin
      r_st_load  <= 1'b0;
      r_st_sel   <= 2'd0;
      r_key_load <= 1'b0;
      r_key_step <= 1'b0;
      r_rcon     <= 8'h00;
      if (w_abort && r_state != S_IDLE) begin
        r_state     <= S_IDLE;
        r_round     <= 4'd0;
        r_lat       <= 2'd0;
        r_busy      <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_accept) begin
              r_state     <= S_INIT;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
              r_round     <= 4'd0;
              r_rc        <= 8'h01;
              r_st_load   <= 1'b1;
              r_st_sel    <= 2'd0;
              r_key_load  <= 1'b1;
            end else if (r_state == S_DONE && out_ready) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
              r_round     <= 4'd0;
            end
          end
          S_INIT: begin
            r_state    <= S_SUB;
            r_round    <= 4'd1;
            r_lat      <= 2'd0;
            r_key_step <= 1'b1;
            r_rcon     <= r_rc;
            r_rc       <= w_xtime;
          end
          S_SUB: begin
            if (r_lat == LAT_LAST) begin
              r_state   <= S_MIX;
              r_st_load <= 1'b1;
              r_st_sel  <= w_last_round ? 2'd2 : 2'd1;
            end else begin
              r_lat <= r_lat + 2'd1;
            end
          end
          S_MIX: begin
            if (w_last_round) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              // key_step leads the MIX that uses the new key by SBOX_LAT cycles.
              r_state    <= S_SUB;
              r_round    <= r_round + 4'd1;
              r_lat      <= 2'd0;
              r_key_step <= 1'b1;
              r_rcon     <= r_rc;
              r_rc       <= w_xtime;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign st_sel    = r_st_sel;
  assign key_load  = r_key_load;
  assign round     = r_round;

`ifdef AES_ROUND_CTRL_ABORT_EN
  // Suppress state/key updates in the cycle an abort is requested.
  assign st_load  = r_st_load & ~abort;
  assign key_step = r_key_step & ~abort;
  assign rcon     = r_rcon & {8{~abort}};
`else
  assign st_load  = r_st_load;
  assign key_step = r_key_step;
  assign rcon     = r_rcon;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed bench for aes_round_ctrl (default and NR=14/SBOX_LAT=3 instances).
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic       a_st_load, a_key_load, a_key_step;
  logic [1:0] a_st_sel;
  logic [7:0] a_rcon;
  logic [3:0] a_round;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic       b_st_load, b_key_load, b_key_step;
  logic [1:0] b_st_sel;
  logic [7:0] b_rcon;
  logic [3:0] b_round;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic       a_abort, b_abort;
`endif

  aes_round_ctrl u_dut_a (
    .clk(clk), .rst(rst),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(a_abort),
`endif
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .busy(a_busy), .st_load(a_st_load), .st_sel(a_st_sel), .key_load(a_key_load),
    .key_step(a_key_step), .rcon(a_rcon), .round(a_round)
  );

  aes_round_ctrl #(.NR(14), .SBOX_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(b_abort),
`endif
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy), .st_load(b_st_load), .st_sel(b_st_sel), .key_load(b_key_load),
    .key_step(b_key_step), .rcon(b_rcon), .round(b_round)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rc_tab [14];
  logic [7:0] s_rdy, s_ov, s_busy, s_ld, s_sel, s_kl, s_ks, s_rc, s_rnd;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input bit b);
    if (b) begin
      s_rdy = 8'(b_in_ready); s_ov = 8'(b_out_valid); s_busy = 8'(b_busy);
      s_ld = 8'(b_st_load); s_sel = 8'(b_st_sel); s_kl = 8'(b_key_load);
      s_ks = 8'(b_key_step); s_rc = b_rcon; s_rnd = 8'(b_round);
    end else begin
      s_rdy = 8'(a_in_ready); s_ov = 8'(a_out_valid); s_busy = 8'(a_busy);
      s_ld = 8'(a_st_load); s_sel = 8'(a_st_sel); s_kl = 8'(a_key_load);
      s_ks = 8'(a_key_step); s_rc = a_rcon; s_rnd = 8'(a_round);
    end
  endtask

  task automatic drv(input bit b, input logic iv, input logic ordy);
    if (b) begin b_in_valid = iv; b_out_ready = ordy; end
    else   begin a_in_valid = iv; a_out_ready = ordy; end
  endtask

  // Accepts one block (from IDLE or DONE) and checks every cycle up to the first DONE cycle.
  task automatic run_block(input bit b, input int nr, input int lat, input logic hold);
    int n;
    int r;
    int ph;
    n = nr * (lat + 1);
    drv(b, 1'b1, 1'b1);
    #1; smp(b);
    chk("accept in_ready", s_rdy, 8'd1);
    @(posedge clk); #1;
    drv(b, hold, 1'b0);
    #1; smp(b);
    chk("init st_load", s_ld, 8'd1);
    chk("init st_sel", s_sel, 8'd0);
    chk("init key_load", s_kl, 8'd1);
    chk("init round", s_rnd, 8'd0);
    chk("init busy", s_busy, 8'd1);
    chk("init out_valid", s_ov, 8'd0);
    chk("init in_ready", s_rdy, 8'd0);
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clk); #1; smp(b);
      if (k <= n) begin
        r  = (k - 1) / (lat + 1) + 1;
        ph = (k - 1) % (lat + 1);
        chk($sformatf("k%0d key_step", k), s_ks, (ph == 0) ? 8'd1 : 8'd0);
        chk($sformatf("k%0d rcon", k), s_rc, (ph == 0) ? rc_tab[r-1] : 8'h00);
        chk($sformatf("k%0d st_load", k), s_ld, (ph == lat) ? 8'd1 : 8'd0);
        chk($sformatf("k%0d st_sel", k), s_sel, (ph != lat) ? 8'd0 : ((r == nr) ? 8'd2 : 8'd1));
        chk($sformatf("k%0d round", k), s_rnd, 8'(r));
        chk($sformatf("k%0d key_load", k), s_kl, 8'd0);
        chk($sformatf("k%0d out_valid", k), s_ov, 8'd0);
        chk($sformatf("k%0d in_ready", k), s_rdy, 8'd0);
      end else begin
        chk("done out_valid", s_ov, 8'd1);
        chk("done round", s_rnd, 8'(nr));
        chk("done st_load", s_ld, 8'd0);
        chk("done key_step", s_ks, 8'd0);
        chk("done in_ready", s_rdy, 8'd0);
        chk("done busy", s_busy, 8'd1);
      end
    end
  endtask

  task automatic release_done(input bit b);
    drv(b, 1'b0, 1'b1);
    @(posedge clk); #1;
    drv(b, 1'b0, 1'b0);
    smp(b);
    chk("release busy", s_busy, 8'd0);
    chk("release out_valid", s_ov, 8'd0);
    chk("release round", s_rnd, 8'd0);
    chk("release in_ready", s_rdy, 8'd1);
  endtask

  initial begin
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
               8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b0, 1'b0);
`ifdef AES_ROUND_CTRL_ABORT_EN
    a_abort = 1'b0;
    b_abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1; smp(1'b0);
    chk("rst in_ready", s_rdy, 8'd1);
    chk("rst busy", s_busy, 8'd0);
    chk("rst out_valid", s_ov, 8'd0);
    chk("rst st_load", s_ld, 8'd0);
    chk("rst st_sel", s_sel, 8'd0);
    chk("rst key_load", s_kl, 8'd0);
    chk("rst key_step", s_ks, 8'd0);
    chk("rst rcon", s_rc, 8'h00);
    chk("rst round", s_rnd, 8'd0);
    smp(1'b1);
    chk("rst b in_ready", s_rdy, 8'd1);
    chk("rst b rcon", s_rc, 8'h00);

    rst = 1'b0;
    @(posedge clk); #1; smp(1'b0);
    chk("idle busy", s_busy, 8'd0);
    chk("idle in_ready", s_rdy, 8'd1);

    // Single block with in_valid held high throughout: must be ignored while busy.
    run_block(1'b0, 10, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; smp(1'b0);
      chk($sformatf("bp%0d out_valid", i), s_ov, 8'd1);
      chk($sformatf("bp%0d in_ready", i), s_rdy, 8'd0);
      chk($sformatf("bp%0d round", i), s_rnd, 8'd10);
      chk($sformatf("bp%0d key_load", i), s_kl, 8'd0);
    end
    drv(1'b0, 1'b0, 1'b1);
    #1; smp(1'b0);
    chk("done in_ready follows out_ready", s_rdy, 8'd1);
    release_done(1'b0);

    // Back-to-back: the second accept happens in the DONE cycle of the first.
    run_block(1'b0, 10, 1, 1'b0);
    run_block(1'b0, 10, 1, 1'b0);
    release_done(1'b0);

    // NR=14, SBOX_LAT=3: out_valid 57 edges after accept.
    run_block(1'b1, 14, 3, 1'b0);
    release_done(1'b1);

`ifdef AES_ROUND_CTRL_ABORT_EN
    drv(1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drv(1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    a_abort = 1'b1;
    #1; smp(1'b0);
    chk("abort cycle round", s_rnd, 8'd4);
    chk("abort cycle key_step", s_ks, 8'd0);
    chk("abort cycle st_load", s_ld, 8'd0);
    @(posedge clk); #1;
    a_abort = 1'b0;
    smp(1'b0);
    chk("after abort busy", s_busy, 8'd0);
    chk("after abort out_valid", s_ov, 8'd0);
    chk("after abort round", s_rnd, 8'd0);
    repeat (3) @(posedge clk);
    #1; smp(1'b0);
    chk("after abort still idle", s_ov, 8'd0);
    run_block(1'b0, 10, 1, 1'b0);
    release_done(1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the AES-128 encryption datapath. It accepts a block start handshake and steps the state register through the initial AddRoundKey and NR rounds. It allows for the registered `sub_bytes` latency in each round and drives the mux selects, key-expansion advance and rcon. It sits beside `sub_bytes`/shift_rows/mix_columns/add_round_key and owns no data, only control.

## Interface
- `NR`, 10: number of rounds, legal range 1..14.
- `SBOX_LAT`, 1: cycles from `sub_bytes` din to dout, legal range 1..4.

Ports (name, direction, width, meaning):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: plaintext and key are presented and stable until accepted.
- `in_ready` out 1: block accepted on a cycle where `in_valid && in_ready`.
- `out_valid` out 1: ciphertext in the state register is valid.
- `out_ready` in 1: consumer takes the ciphertext.
- `busy` out 1: high in any state other than IDLE.
- `st_load` out 1: state register load enable.
- `st_sel` out 2: state mux select. 0 = din^key (initial), 1 = full round, 2 = final round (no MixColumns), 3 unused.
- `key_load` out 1: key expander loads the cipher key.
- `key_step` out 1: key expander computes the next round key.
- `rcon` out 8: round constant, valid while `key_step`=1, otherwise 0.
- `round` out 4: current round number, 0 during INIT and IDLE.

## Operation
States and transitions:
- IDLE → INIT on accept.
- INIT → SUB, after 1 cycle.
- SUB → MIX after SBOX_LAT cycles, counted by an internal latency counter.
- MIX → SUB if `round` < NR, otherwise → DONE.
- DONE → IDLE on `out_ready`, or → INIT on `out_ready && in_valid` (back-to-back).

Per-state outputs:
- IDLE: all control outputs 0. `in_ready`=1.
- INIT: `st_load`=1, `st_sel`=0, `key_load`=1, `round`←1 at exit.
- SUB, first cycle: `key_step`=1, `rcon`=RC[round]. Otherwise all strobes are 0.
- MIX: `st_load`=1. `st_sel`=1 if `round`<NR, otherwise 2. `round` increments at exit unless the next state is DONE.
- DONE: `out_valid`=1. `in_ready`=`out_ready`. `round` holds NR.

rcon arithmetic:
- Internal 8-bit register, set to 0x01 on key_load.
- Advanced by GF(2^8) xtime after each key_step: shift left 1, XOR 0x1B if bit 7 was set.
- Sequence: 01,02,04,08,10,20,40,80,1B,36,6C,D8,AB,4D.

Boundary conditions:
- `in_valid` while busy and not in DONE: ignored, `in_ready`=0.
- `out_ready` outside DONE: ignored.
- `rst` in any state: IDLE next edge, counters cleared, no further strobes.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `out_valid`=0, `st_load`=0, `st_sel`=0, `key_load`=0, `key_step`=0, `rcon`=0, `round`=0. The rcon register resets to 0x01.
- Accept edge E0: INIT occupies the cycle after E0.
- `out_valid` rises 1+NR*(SBOX_LAT+1) edges after E0. Defaults: 21 edges.
- Throughput with `out_ready` held high: one block per 1+NR*(SBOX_LAT+1)+1 cycles. The DONE cycle overlaps the next accept.
- `key_step` precedes the MIX that consumes the key by SBOX_LAT cycles, so the key expander gets ≥1 cycle of registered latency.
- All outputs are registered or decoded from state register bits only. There is no combinational path from `in_valid`/`out_ready` except to `in_ready` in DONE.

## Configuration
- `AES_ROUND_CTRL_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge. `out_valid` is not asserted for that block, and `st_load`/`key_step` are 0 in the abort cycle.
  - `abort` has priority over `out_ready` in DONE.
  - `abort` is ignored in IDLE.
- Undefined: no `abort` port, and the FSM is only interruptible by `rst`.

## Test plan
- Reset then idle: hold `rst` 2 cycles → all outputs at reset values, `in_ready`=1, `rcon`=0.
- Single block, defaults: accept at E0 → one INIT, 10 key_steps with rcon 01..36 in order, 10 `st_load` MIX pulses (`st_sel` 1×9 then 2), `out_valid` at E0+21. Run against the datapath: FIPS-197 C.1 key 000102..0F, pt 00112233..FF → ct 69C4E0D86A7B0430D8CDB78070B4C55A.
- Backpressure: `out_ready`=0 for 5 cycles in DONE → `out_valid` held, `in_ready`=0, `round`=10. Then `out_ready`=1 → IDLE next edge.
- Back-to-back: `in_valid`=1 and `out_ready`=1 in DONE → second INIT on the following cycle, rcon restarts at 01.
- SBOX_LAT=3, NR=14: `out_valid` at E0+57, `key_step` 3 cycles before each MIX.
- ABORT_EN: `abort` in round 4 SUB → IDLE next edge, no `out_valid`. A new accept then runs a full 21-cycle block.
